program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Writer side of the instruction memory that fetch reads. Accepts a byte stream from the host/bench
//  over valid/ready and packs 4 bytes per 32-bit opcode word, first byte in [31:24] to match ope.
//  Writes each word to sequential instruction-memory addresses from 0.
//  Holds cpu_reset asserted during loading and releases it once the load completes, so cpu_clock/fetch start at eip=0.
// PARAMETERS
//  ADDR_W     8      instruction memory word-address width
//  MAX_WORDS  256    word capacity; must be <= 2**ADDR_W
//  PAD_BYTE   8'h90  fill value for unused bytes of a final partial word (x86 NOP)
// PORTS
//  clk        in   1       system clock; all state changes on posedge
//  reset      in   1       asynchronous, active-low (0 = reset)
//  start      in   1       1-cycle pulse; arms a new load (ignored while COLLECT/WRITE)
//  in_valid   in   1       byte on in_data is valid
//  in_data    in   8       program byte
//  in_last    in   1       qualifies final byte of program (sampled with in_valid)
//  in_ready   out  1       loader accepts a byte this cycle
//  mem_we     out  1       instruction-memory write strobe, 1 cycle per word
//  mem_addr   out  ADDR_W  word address of write
//  mem_wdata  out  32      packed word
//  cpu_reset  out  1       active-high reset to CPU (fetch/decode/registers)
//  done       out  1       load finished OK; held until next start
//  error      out  1       overflow: program longer than MAX_WORDS words; held until next start
//  word_count out  ADDR_W+1 number of words written in current/last load
// BEHAVIOUR
//  Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0,
//   error=0, word_count=0, byte index=0. Reset mid-load aborts; nothing further is written.
//  States: IDLE, COLLECT, WRITE, DONE, ERROR.
//  IDLE: cpu_reset=1. start -> COLLECT, addr=0, word_count=0, byte index=0.
//  COLLECT: in_ready=1. Byte accepted iff in_valid&in_ready at posedge.
//   Byte k (0..3) of a word goes to wdata[31-8k -: 8].
//   On accepting byte 3, or any byte with in_last=1: -> WRITE. For in_last at k<3, bytes k+1..3 = PAD_BYTE.
//  WRITE: exactly 1 cycle. mem_we=1, mem_addr=current addr, in_ready=0.
//   Next cycle: addr+1, word_count+1.
//   If the word held in_last -> DONE.
//   Else, if word_count after increment == MAX_WORDS -> ERROR.
//   Otherwise -> COLLECT with byte index=0.
//  DONE: cpu_reset=0 from the cycle after WRITE; done=1; in_ready=0.
//  ERROR: cpu_reset stays 1; error=1; in_ready=0; no further writes.
//  start in DONE/ERROR: -> COLLECT, cpu_reset=1, done=0, error=0, addr=0, word_count=0.
//  start in COLLECT/WRITE is ignored.
//  Latency: 4th (or last) byte accepted at edge N -> mem_we high during cycle N+1 -> next byte accepted no earlier than edge N+2.
//   Throughput: 4 bytes per 5 cycles max.
//  in_valid while in_ready=0: byte is not consumed; the sender holds it stable.
//  in_last with no preceding word pending is still a 1-byte word (padded). An empty program is not supported.
//  Contract: mem_wdata is stable while mem_we=1; mem_addr never exceeds MAX_WORDS-1.
// TESTING
//  1. Reset low mid-COLLECT after 2 bytes -> cpu_reset=1, mem_we never pulses, word_count=0, in_ready=0.
//  2. start, stream 8b 5d 08 83, e4 f0 00 c3 (last on c3) -> writes [0]=32'h8b5d0883, [1]=32'he4f000c3;
//     done=1, cpu_reset=0, word_count=2.
//  3. start, bytes 55 89 e5 (last on e5) -> single write [0]=32'h5589e590; done=1.
//  4. in_valid toggled randomly, data held while not ready -> same memory image as scenario 2, no byte lost/duplicated.
//  5. MAX_WORDS=2, stream 12 bytes no last -> 2 writes, then error=1, cpu_reset=1, in_ready=0.
//  6. start in DONE -> cpu_reset back to 1 next cycle; reload 4 bytes aa bb cc dd (last) -> [0]=32'haabbccdd.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream loader for the instruction memory: packs 4 bytes per big-endian opcode word,
// writes words from address 0 and holds the CPU in reset until the whole program is in place.
module program_loader #(
  parameter int          ADDR_W    = 8,
  parameter int          MAX_WORDS = 256,
  parameter logic [7:0]  PAD_BYTE  = 8'h90
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_inc;
  logic [31:0]       wdata_q, wdata_d;
  logic              accept;
  logic              arm;

  assign accept    = (state_q == S_COLLECT) && in_valid;
  assign count_inc = count_q + (ADDR_W + 1)'(1);
  // start only re-arms from a quiescent state; mid-load pulses are dropped.
  assign arm       = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

  // Next-state and Moore outputs.
  // NOTE: every output of this combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    cpu_reset = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        in_ready = 1'b1;
        if (accept && (byte_idx_q == 2'd3 || in_last)) state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (last_q)                    state_d = S_DONE;
        else if (count_inc == MAX_CNT) state_d = S_ERROR;
        else                           state_d = S_COLLECT;
      end
      S_DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        if (start) state_d = S_COLLECT;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) state_d = S_COLLECT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lane insert: the accepted byte lands in its lane; a final byte pads the lanes after it.
  always_comb begin
    wdata_d = wdata_q;
    for (int j = 0; j < 4; j++) begin
      if (j == int'(byte_idx_q))                wdata_d[31-8*j -: 8] = in_data;
      else if (j > int'(byte_idx_q) && in_last) wdata_d[31-8*j -: 8] = PAD_BYTE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx_q <= 2'd0;
      last_q     <= 1'b0;
      addr_q     <= '0;
      count_q    <= '0;
      wdata_q    <= '0;
    end else if (arm) begin
      byte_idx_q <= 2'd0;
      last_q     <= 1'b0;
      addr_q     <= '0;
      count_q    <= '0;
    end else if (accept) begin
      wdata_q    <= wdata_d;
      byte_idx_q <= byte_idx_q + 2'd1;
      last_q     <= in_last;
    end else if (state_q == S_WRITE) begin
      byte_idx_q <= 2'd0;
      count_q    <= count_inc;
      // Address saturates at the last slot so it never points past the memory.
      if (count_inc != MAX_CNT) addr_q <= addr_q + ADDR_W'(1);
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a default-size instance (a) and a 2-word instance (b)
// share the byte stream; each is started separately.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;

  logic        ready_a, we_a, cpu_rst_a, done_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  cnt_a;

  logic        ready_b, we_b, cpu_rst_b, done_b, err_b;
  logic [7:0]  addr_b;
  logic [31:0] wdata_b;
  logic [8:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  logic [7:0]  log_a_addr[$];
  logic [31:0] log_a_data[$];
  logic [7:0]  log_b_addr[$];
  logic [31:0] log_b_data[$];

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(8), .MAX_WORDS(256), .PAD_BYTE(8'h90)) u_dut_a (
    .clk(clk), .reset(rst_n), .start(start_a),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(ready_a),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .cpu_reset(cpu_rst_a), .done(done_a), .error(err_a), .word_count(cnt_a)
  );

  program_loader #(.ADDR_W(8), .MAX_WORDS(2), .PAD_BYTE(8'h90)) u_dut_b (
    .clk(clk), .reset(rst_n), .start(start_b),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(ready_b),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .cpu_reset(cpu_rst_b), .done(done_b), .error(err_b), .word_count(cnt_b)
  );

  // Write logs: one entry per cycle with mem_we high.
  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      log_a_addr.push_back(addr_a);
      log_a_data.push_back(wdata_a);
    end
    if (we_b === 1'b1) begin
      log_b_addr.push_back(addr_b);
      log_b_data.push_back(wdata_b);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit to_b);
    if (to_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
  endtask

  // Offers one byte, optionally after idle cycles with in_valid low; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] d, input logic l, input bit to_b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (!(to_b ? ready_b : ready_a) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("send_handshake", 64'(n < 40), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  logic [7:0] prog2 [8];
  logic [7:0] prog3 [3];
  logic [7:0] prog6 [4];
  int base;

  initial begin
    prog2 = '{8'h8b, 8'h5d, 8'h08, 8'h83, 8'he4, 8'hf0, 8'h00, 8'hc3};
    prog3 = '{8'h55, 8'h89, 8'he5};
    prog6 = '{8'haa, 8'hbb, 8'hcc, 8'hdd};
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cpu_reset", cpu_rst_a, 1);
    check("rst_in_ready",  ready_a, 0);
    check("rst_mem_we",    we_a, 0);
    check("rst_mem_addr",  addr_a, 0);
    check("rst_mem_wdata", wdata_a, 0);
    check("rst_done",      done_a, 0);
    check("rst_error",     err_a, 0);
    check("rst_word_count", cnt_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: reset mid-COLLECT aborts the load
    pulse_start(1'b0);
    check("s1_ready_collect", ready_a, 1);
    base = log_a_addr.size();
    send(8'h8b, 1'b0, 1'b0, 0);
    send(8'h5d, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("s1_cpu_reset", cpu_rst_a, 1);
    check("s1_in_ready",  ready_a, 0);
    check("s1_word_count", cnt_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("s1_no_writes", 64'(log_a_addr.size() - base), 0);
    check("s1_idle_ready", ready_a, 0);

    // 2: two full words, back-to-back
    pulse_start(1'b0);
    base = log_a_addr.size();
    for (int i = 0; i < 8; i++) send(prog2[i], 1'b0 + (i == 7), 1'b0, 0);
    check("s2_write_we",    we_a, 1);
    check("s2_write_addr",  addr_a, 1);
    check("s2_write_data",  wdata_a, 32'he4f000c3);
    check("s2_write_cpurst", cpu_rst_a, 1);
    @(negedge clk);
    check("s2_done",       done_a, 1);
    check("s2_cpu_reset",  cpu_rst_a, 0);
    check("s2_word_count", cnt_a, 2);
    check("s2_ready",      ready_a, 0);
    check("s2_nwrites",    64'(log_a_addr.size() - base), 2);
    check("s2_addr0",      log_a_addr[base],   0);
    check("s2_word0",      log_a_data[base],   32'h8b5d0883);
    check("s2_addr1",      log_a_addr[base+1], 1);
    check("s2_word1",      log_a_data[base+1], 32'he4f000c3);

    // 4: random valid gaps and an ignored mid-load start give the same image
    pulse_start(1'b0);
    check("s4_cpu_reset", cpu_rst_a, 1);
    check("s4_done_clr",  done_a, 0);
    base = log_a_addr.size();
    for (int i = 0; i < 8; i++) begin
      send(prog2[i], 1'b0 + (i == 7), 1'b0, int'($urandom_range(0, 2)));
      if (i == 1) begin
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
      end
    end
    @(negedge clk);
    check("s4_done",    done_a, 1);
    check("s4_nwrites", 64'(log_a_addr.size() - base), 2);
    check("s4_word0",   log_a_data[base],   32'h8b5d0883);
    check("s4_word1",   log_a_data[base+1], 32'he4f000c3);
    check("s4_addr1",   log_a_addr[base+1], 1);

    // 3: partial final word padded with NOPs
    pulse_start(1'b0);
    base = log_a_addr.size();
    for (int i = 0; i < 3; i++) send(prog3[i], 1'b0 + (i == 2), 1'b0, 0);
    @(negedge clk);
    check("s3_done",    done_a, 1);
    check("s3_count",   cnt_a, 1);
    check("s3_nwrites", 64'(log_a_addr.size() - base), 1);
    check("s3_addr0",   log_a_addr[base], 0);
    check("s3_word0",   log_a_data[base], 32'h5589e590);

    // 6: start in DONE re-asserts cpu_reset, reload one word
    pulse_start(1'b0);
    check("s6_cpu_reset", cpu_rst_a, 1);
    check("s6_done_clr",  done_a, 0);
    check("s6_count_clr", cnt_a, 0);
    base = log_a_addr.size();
    for (int i = 0; i < 4; i++) send(prog6[i], 1'b0 + (i == 3), 1'b0, 0);
    @(negedge clk);
    check("s6_done",    done_a, 1);
    check("s6_cpu_rel", cpu_rst_a, 0);
    check("s6_nwrites", 64'(log_a_addr.size() - base), 1);
    check("s6_word0",   log_a_data[base], 32'haabbccdd);

    // 5: overflow on the 2-word instance
    check("s5_b_idle", cpu_rst_b, 1);
    pulse_start(1'b1);
    base = log_b_addr.size();
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 1'b0, 1'b1, 0);
    check("s5_write_addr", addr_b, 1);
    @(negedge clk);
    check("s5_error",     err_b, 1);
    check("s5_cpu_reset", cpu_rst_b, 1);
    check("s5_in_ready",  ready_b, 0);
    check("s5_done",      done_b, 0);
    check("s5_count",     cnt_b, 2);
    check("s5_addr_cap",  64'(addr_b <= 8'd1), 1);
    in_valid = 1'b1;
    in_data  = 8'h18;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("s5_ready_held", ready_b, 0);
    end
    in_valid = 1'b0;
    check("s5_nwrites", 64'(log_b_addr.size() - base), 2);
    check("s5_word0",   log_b_data[base],   32'h10111213);
    check("s5_word1",   log_b_data[base+1], 32'h14151617);
    check("s5_a_quiet", done_a, 1);
    pulse_start(1'b1);
    check("s5_err_clr", err_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
